ntt_commutor_sched: RTL and testbench
=====================================

Name: ntt_commutor_sched

Overview:
- Sequencing controller for the 8-lane NTT commutator pipeline (delay units plus commutor stages).
- Admits one polynomial's frames from an upstream source through a valid/ready handshake.
- Generates each commutator stage's valid strobe and 3-bit permutation select, delayed to match pipeline latency.
- Issues the end-of-transform pulse that clears the stage counters once the last frame has drained.

Parameters:
- FRAMES, 64, frames per polynomial (8 coefficients per frame); power of two, minimum 8.
- STAGE1_LAT, 9, cycles from a stage-0 strobe to the matching stage-1 strobe (delay units between stages); minimum 1.
- TAIL_LAT, 8, cycles from the last stage-1 strobe to the ntt_end pulse; minimum 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; honoured only in IDLE.
- in_valid  in  1  upstream frame available.
- in_ready  out  1  scheduler accepts a frame this cycle.
- s0_valid  out  1  stage-0 commutator valid_in.
- s0_sel  out  3  stage-0 commutator count/select.
- s1_valid  out  1  stage-1 commutator valid_in.
- s1_sel  out  3  stage-1 commutator count/select.
- frame_idx  out  $clog2(FRAMES)  accepted-frame index within the current polynomial.
- busy  out  1  high in every state except IDLE.
- ntt_end  out  1  one-cycle pulse at transform completion.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE.
  - All outputs 0; s0_sel=s1_sel=0; frame_idx=0.
  - Delay line cleared.
  - Reset mid-transform aborts immediately; no ntt_end pulse is produced.
- States: IDLE, LOAD, DRAIN, END.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD next cycle; frame_idx, accepted count, s0_sel and s1_sel cleared.
- LOAD:
  - in_ready=1 (registered, asserted from the first LOAD cycle).
  - accept = in_valid & in_ready.
  - Each accept: s0_valid=1 for that cycle (combinational from accept); frame_idx increments.
  - s0_sel shows the pre-increment count, then increments mod 8 on the following edge, so the first accepted frame sees s0_sel=0.
  - When the accept with frame_idx=FRAMES-1 occurs: in_ready drops next cycle, frame_idx wraps to 0, state -> DRAIN.
  - Gaps in in_valid stall the sequence; s0_sel holds during gaps.
  - start is ignored outside IDLE.
- Stage-1 alignment:
  - A STAGE1_LAT-deep shift register of accept produces s1_valid exactly STAGE1_LAT cycles after each s0_valid.
  - This holds in every state, so stage-1 strobes continue into DRAIN.
  - s1_sel: own mod-8 counter, presented pre-increment with each s1_valid.
- DRAIN:
  - Stage-1 strobes are counted.
  - Once FRAMES have been seen, a TAIL_LAT down-counter starts.
  - When it expires -> END.
- END:
  - ntt_end=1 for exactly one cycle; s0_sel and s1_sel cleared on the same edge.
  - -> IDLE next cycle.
  - start asserted during END is ignored; start must be re-asserted in IDLE.
- Latency: ntt_end rises exactly TAIL_LAT cycles after the cycle holding the last s1_valid.
- Width rules:
  - All select counters wrap 7->0 with no carry out.
  - Stage-1 frame counter is $clog2(FRAMES)+1 bits wide and never overflows.
- Simultaneous events:
  - rst overrides everything.
  - An accept in the same cycle as LOAD->DRAIN is the final frame and is counted.

Test Plan:
- Reset: hold rst 3 cycles mid-LOAD after 10 frames -> next cycle busy=0, in_ready=0, s1_valid=0; later start gives s0_sel=0 on the first frame.
- Back-to-back: FRAMES=64, STAGE1_LAT=9, TAIL_LAT=8, start then in_valid held high:
  - 64 consecutive s0_valid with s0_sel 0,1,…,7 repeating; in_ready drops after 64 accepts.
  - s1_valid strobes are the same pattern shifted by 9 cycles.
  - ntt_end pulses 8 cycles after the final s1_valid.
- Bubbles: in_valid pattern 0,0,1 repeating:
  - s0_valid every third cycle; selects advance only on accepts.
  - s1_valid mirrors that pattern 9 cycles later; exactly 64 strobes per stage; ntt_end still arrives.
- start in LOAD/DRAIN: pulse start mid-transform -> no restart, frame count unaffected, exactly one ntt_end; then start in IDLE -> new transform with frame_idx=0.
- Boundary configuration: FRAMES=8, STAGE1_LAT=1, TAIL_LAT=1 -> s0_sel runs 0..7 once; s1_valid lags s0_valid by exactly 1 cycle; ntt_end 1 cycle after the last s1_valid, then busy=0.

Source files
------------

// File: rtl/ntt_commutor_sched.sv
// Sequencing controller for the 8-lane NTT commutator pipeline: admits one
// polynomial's frames, strobes both commutator stages and signals completion.
module ntt_commutor_sched #(
    parameter int unsigned FRAMES     = 64,
    parameter int unsigned STAGE1_LAT = 9,
    parameter int unsigned TAIL_LAT   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic                      s0_valid_o,
    output logic [2:0]                s0_sel_o,
    output logic                      s1_valid_o,
    output logic [2:0]                s1_sel_o,
    output logic [$clog2(FRAMES)-1:0] frame_idx_o,
    output logic                      busy_o,
    output logic                      ntt_end_o
);

    localparam int unsigned FW = $clog2(FRAMES);
    localparam int unsigned CW = FW + 1;
    localparam int unsigned TW = $clog2(TAIL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_END   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [FW-1:0]         frame_idx_q, frame_idx_d;
    logic [2:0]            s0_sel_q, s0_sel_d;
    logic [2:0]            s1_sel_q, s1_sel_d;
    logic [STAGE1_LAT-1:0] sr_q, sr_d;
    logic [CW-1:0]         s1_cnt_q, s1_cnt_d;
    logic [TW-1:0]         tail_q, tail_d;

    logic accept_c;
    logic s1_strobe_c;
    logic last_s1_c;
    logic tail_done_c;

    assign accept_c    = in_valid_i && (state_q == S_LOAD);
    assign s1_strobe_c = sr_q[STAGE1_LAT-1];
    assign last_s1_c   = s1_strobe_c && (s1_cnt_q == CW'(FRAMES - 1));
    // With a one-cycle tail the final stage-1 strobe itself must trigger END.
    assign tail_done_c = last_s1_c ? (TAIL_LAT == 1) : (tail_q == TW'(1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept_c && (frame_idx_q == FW'(FRAMES - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tail_done_c) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; control outputs follow the state register directly
    always_comb begin
        in_ready_o  = 1'b0;
        busy_o      = 1'b1;
        ntt_end_o   = 1'b0;
        s0_valid_o  = accept_c;
        s1_valid_o  = s1_strobe_c;
        s0_sel_o    = s0_sel_q;
        s1_sel_o    = s1_sel_q;
        frame_idx_o = frame_idx_q;
        case (state_q)
            S_IDLE:  busy_o     = 1'b0;
            S_LOAD:  in_ready_o = 1'b1;
            S_END:   ntt_end_o  = 1'b1;
            default: busy_o     = 1'b1;
        endcase
    end

    // Frame, select and tail counters plus the stage-1 alignment delay line
    always_comb begin
        frame_idx_d = frame_idx_q;
        s0_sel_d    = s0_sel_q;
        s1_sel_d    = s1_sel_q;
        s1_cnt_d    = s1_cnt_q;
        tail_d      = tail_q;
        sr_d        = STAGE1_LAT'({sr_q, accept_c});

        if (accept_c) begin
            frame_idx_d = frame_idx_q + FW'(1);
            s0_sel_d    = s0_sel_q + 3'd1;
        end

        if (s1_strobe_c) begin
            s1_sel_d = s1_sel_q + 3'd1;
            s1_cnt_d = s1_cnt_q + CW'(1);
        end

        if (last_s1_c) begin
            tail_d = TW'(TAIL_LAT - 1);
        end else if (tail_q != '0) begin
            tail_d = tail_q - TW'(1);
        end

        if ((state_q == S_IDLE) && start_i) begin
            frame_idx_d = '0;
            s0_sel_d    = '0;
            s1_sel_d    = '0;
            s1_cnt_d    = '0;
            tail_d      = '0;
        end

        if (state_q == S_END) begin
            s0_sel_d = '0;
            s1_sel_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_idx_q <= '0;
            s0_sel_q    <= '0;
            s1_sel_q    <= '0;
            s1_cnt_q    <= '0;
            tail_q      <= '0;
            sr_q        <= '0;
        end else begin
            frame_idx_q <= frame_idx_d;
            s0_sel_q    <= s0_sel_d;
            s1_sel_q    <= s1_sel_d;
            s1_cnt_q    <= s1_cnt_d;
            tail_q      <= tail_d;
            sr_q        <= sr_d;
        end
    end

endmodule

// File: tb/tb_ntt_commutor_sched.sv
// Bench for ntt_commutor_sched: default and minimum configurations share stimulus
// and are checked every cycle against a timing model built from accept timestamps.
module tb_ntt_commutor_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst      = 1'b1;
    logic start    = 1'b0;
    logic in_valid = 1'b0;

    logic       in_ready [2];
    logic       s0_valid [2];
    logic       s1_valid [2];
    logic       busy     [2];
    logic       ntt_end  [2];
    logic [2:0] s0_sel   [2];
    logic [2:0] s1_sel   [2];
    logic [5:0] fidx_a;
    logic [2:0] fidx_b;

    ntt_commutor_sched #(.FRAMES(64), .STAGE1_LAT(9), .TAIL_LAT(8)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready[0]),
        .s0_valid_o  (s0_valid[0]),
        .s0_sel_o    (s0_sel[0]),
        .s1_valid_o  (s1_valid[0]),
        .s1_sel_o    (s1_sel[0]),
        .frame_idx_o (fidx_a),
        .busy_o      (busy[0]),
        .ntt_end_o   (ntt_end[0])
    );

    ntt_commutor_sched #(.FRAMES(8), .STAGE1_LAT(1), .TAIL_LAT(1)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready[1]),
        .s0_valid_o  (s0_valid[1]),
        .s0_sel_o    (s0_sel[1]),
        .s1_valid_o  (s1_valid[1]),
        .s1_sel_o    (s1_sel[1]),
        .frame_idx_o (fidx_b),
        .busy_o      (busy[1]),
        .ntt_end_o   (ntt_end[1])
    );

    // Configuration of each instance: frames, stage-1 latency, tail latency
    int mf [2] = '{64, 8};
    int ml [2] = '{9, 1};
    int mt [2] = '{8, 1};

    int n_checks = 0;
    int n_fail   = 0;
    int now      = 0;

    // Model: phase 0 idle, 1 loading, 2 draining (until the end pulse)
    int ph   [2] = '{0, 0};
    int nacc [2] = '{0, 0};
    int ns1  [2] = '{0, 0};
    int acc_t [2][64];
    bit e_s1  [2];
    bit e_end [2];
    int obs_s0  [2] = '{0, 0};
    int obs_s1  [2] = '{0, 0};
    int obs_end [2] = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, now, got, exp);
        end
    endtask

    task automatic expect_inst(input bit i, input bit chk);
        bit          e_rdy;
        logic [31:0] fid;
        e_rdy  = (ph[i] == 1);
        e_s1[i] = 1'b0;
        if (ns1[i] < nacc[i]) begin
            e_s1[i] = (acc_t[i][6'(ns1[i])] + ml[i] == now);
        end
        e_end[i] = 1'b0;
        if ((ph[i] == 2) && (nacc[i] == mf[i])) begin
            e_end[i] = (acc_t[i][6'(mf[i] - 1)] + ml[i] + mt[i] == now);
        end
        obs_s0[i]  += int'(s0_valid[i]);
        obs_s1[i]  += int'(s1_valid[i]);
        obs_end[i] += int'(ntt_end[i]);
        if (chk) begin
            fid = i ? 32'(fidx_b) : 32'(fidx_a);
            check_eq($sformatf("in_ready%0d", i),  32'(in_ready[i]), 32'(e_rdy));
            check_eq($sformatf("s0_valid%0d", i),  32'(s0_valid[i]), 32'(e_rdy && in_valid));
            check_eq($sformatf("s0_sel%0d", i),    32'(s0_sel[i]),   32'(nacc[i] % 8));
            check_eq($sformatf("frame_idx%0d", i), fid,              32'(nacc[i] % mf[i]));
            check_eq($sformatf("s1_valid%0d", i),  32'(s1_valid[i]), 32'(e_s1[i]));
            check_eq($sformatf("s1_sel%0d", i),    32'(s1_sel[i]),   32'(ns1[i] % 8));
            check_eq($sformatf("busy%0d", i),      32'(busy[i]),     32'(ph[i] != 0));
            check_eq($sformatf("ntt_end%0d", i),   32'(ntt_end[i]),  32'(e_end[i]));
        end
    endtask

    task automatic update_inst(input bit i, input logic st, input logic iv, input logic r);
        if (r) begin
            ph[i]   = 0;
            nacc[i] = 0;
            ns1[i]  = 0;
        end else begin
            if (e_s1[i]) ns1[i]++;
            if ((ph[i] == 1) && iv) begin
                acc_t[i][6'(nacc[i])] = now;
                nacc[i]++;
                if (nacc[i] == mf[i]) ph[i] = 2;
            end
            if (e_end[i]) begin
                ph[i] = 0;
            end else if ((ph[i] == 0) && st) begin
                ph[i]   = 1;
                nacc[i] = 0;
                ns1[i]  = 0;
            end
        end
    endtask

    task automatic cycle(input logic st, input logic iv, input logic r, input bit chk);
        @(negedge clk);
        start    = st;
        in_valid = iv;
        rst      = r;
        #1;
        expect_inst(1'b0, chk);
        expect_inst(1'b1, chk);
        @(posedge clk);
        update_inst(1'b0, st, iv, r);
        update_inst(1'b1, st, iv, r);
        now++;
    endtask

    // mode 0: in_valid held high, 1: pattern 0,0,1, 2: random; optional start pulses
    task automatic run_xfer(input int mode, input int sa1, input int sa2, input string name);
        int   k;
        int   s0a, s1a, ena, s0b, s1b, enb;
        logic iv;
        s0a = obs_s0[0]; s1a = obs_s1[0]; ena = obs_end[0];
        s0b = obs_s0[1]; s1b = obs_s1[1]; enb = obs_end[1];
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        k = 0;
        while (((ph[0] != 0) || (ph[1] != 0)) && (k < 3000)) begin
            k++;
            case (mode)
                0:       iv = 1'b1;
                1:       iv = logic'(k % 3 == 0);
                default: iv = logic'($urandom_range(3, 0) != 0);
            endcase
            cycle(logic'((k == sa1) || (k == sa2)), iv, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq({name, "_idle_a"}, 32'(busy[0]), 32'd0);
        check_eq({name, "_idle_b"}, 32'(busy[1]), 32'd0);
        check_eq({name, "_s0_count_a"}, 32'(obs_s0[0] - s0a), 32'd64);
        check_eq({name, "_s1_count_a"}, 32'(obs_s1[0] - s1a), 32'd64);
        check_eq({name, "_end_count_a"}, 32'(obs_end[0] - ena), 32'd1);
        if (sa1 < 0) begin
            check_eq({name, "_s0_count_b"}, 32'(obs_s0[1] - s0b), 32'd8);
            check_eq({name, "_s1_count_b"}, 32'(obs_s1[1] - s1b), 32'd8);
            check_eq({name, "_end_count_b"}, 32'(obs_end[1] - enb), 32'd1);
        end
    endtask

    initial begin
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort a transform with a 3-cycle reset after 10 accepted frames
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("rst_abort_busy_a", 32'(busy[0]), 32'd0);
        check_eq("rst_abort_rdy_a", 32'(in_ready[0]), 32'd0);

        run_xfer(0, -1, -1, "b2b");
        run_xfer(1, -1, -1, "bubble");
        run_xfer(2, 20, 90, "start_mid");
        repeat (3) run_xfer(2, -1, -1, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
